// File: rtl/wm8731_i2c_seq.sv
// WM8731 power-up sequencer: writes an 8-entry register table as 3-byte I2C writes.
// Optional WM8731_NACK_RETRY_EN: re-send a NACKed word up to 3 times before aborting.
module wm8731_i2c_seq #(
  parameter int         CLK_DIV   = 32,
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         GAP_TICKS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       scl_o,
  output logic       sda_o,
  input  logic       sda_i,
  output logic [2:0] dbg_state
);
  // start is a plain pulse (no handshake): it is accepted only on a cycle where busy=0
  // and the FSM is idle; busy then rises on the following cycle and stays high until
  // done or error is set.
  localparam int QDIV = CLK_DIV / 4;
  localparam int CW   = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int GW   = $clog2(GAP_TICKS + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BITS, S_STOP, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic [3:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [2:0]    idx_q, idx_d;
  logic [23:0]   sh_q, sh_d;
  logic          nack_q, nack_d;
  logic          busy_d, done_d, error_d, scl_d, sda_d;
  logic [CW-1:0] cnt_q;
  logic          qtick;

  assign dbg_state = state_q;
  assign qtick     = busy && (cnt_q == CW'(QDIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                cnt_q <= '0;
    else if (!busy || qtick) cnt_q <= '0;
    else                     cnt_q <= cnt_q + 1'b1;
  end

  function automatic logic [15:0] table_word(input logic [2:0] i);
    case (i)
      3'd0:    table_word = {7'h0F, 9'h000};
      3'd1:    table_word = {7'h06, 9'h072};
      3'd2:    table_word = {7'h04, 9'h012};
      3'd3:    table_word = {7'h05, 9'h000};
      3'd4:    table_word = {7'h07, 9'h00A};
      3'd5:    table_word = {7'h08, 9'h000};
      3'd6:    table_word = {7'h09, 9'h001};
      default: table_word = {7'h06, 9'h062};
    endcase
  endfunction

`ifdef WM8731_NACK_RETRY_EN
  logic [1:0] retry_q, retry_d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) retry_q <= '0;
    else      retry_q <= retry_d;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      nack_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      scl_o   <= 1'b1;
      sda_o   <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      nack_q  <= nack_d;
      busy    <= busy_d;
      done    <= done_d;
      error   <= error_d;
      scl_o   <= scl_d;
      sda_o   <= sda_d;
    end
  end

  // Each qtick drives the line levels of the current phase, then advances the phase.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    nack_d  = nack_q;
    busy_d  = busy;
    done_d  = done;
    error_d = error;
    scl_d   = scl_o;
    sda_d   = sda_o;
`ifdef WM8731_NACK_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          idx_d   = '0;
          phase_d = '0;
          busy_d  = 1'b1;
          state_d = S_START;
`ifdef WM8731_NACK_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      S_START: begin
        if (qtick) begin
          phase_d = phase_q + 1'b1;
          case (phase_q)
            2'd0:    begin scl_d = 1'b1; sda_d = 1'b1; end
            2'd1:    sda_d = 1'b0;
            2'd2:    sda_d = 1'b0;
            default: begin
              scl_d   = 1'b0;
              state_d = S_BITS;
              bit_d   = '0;
              byte_d  = '0;
              nack_d  = 1'b0;
              sh_d    = {DEV_ADDR, 1'b0, table_word(idx_q)};
            end
          endcase
        end
      end
      S_BITS: begin
        if (qtick) begin
          phase_d = phase_q + 1'b1;
          case (phase_q)
            2'd0:    begin scl_d = 1'b0; sda_d = (bit_q == 4'd8) ? 1'b1 : sh_q[23]; end
            2'd1:    ;
            2'd2:    scl_d = 1'b1;
            default: begin
              scl_d = 1'b1;
              if (bit_q == 4'd8) begin
                if (sda_i) nack_d = 1'b1;
                if (sda_i || byte_q == 2'd2) state_d = S_STOP;
                else begin
                  bit_d  = '0;
                  byte_d = byte_q + 1'b1;
                end
              end else begin
                bit_d = bit_q + 1'b1;
                sh_d  = {sh_q[22:0], 1'b0};
              end
            end
          endcase
        end
      end
      S_STOP: begin
        if (qtick) begin
          phase_d = phase_q + 1'b1;
          case (phase_q)
            2'd0:    begin scl_d = 1'b0; sda_d = 1'b0; end
            2'd1:    scl_d = 1'b1;
            2'd2:    sda_d = 1'b1;
            default: begin
              gap_d   = '0;
              state_d = S_GAP;
              if (nack_q) begin
`ifdef WM8731_NACK_RETRY_EN
                if (retry_q == 2'd3) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  error_d = 1'b1;
                end else begin
                  retry_d = retry_q + 1'b1;
                end
`else
                state_d = S_IDLE;
                busy_d  = 1'b0;
                error_d = 1'b1;
`endif
              end
            end
          endcase
        end
      end
      S_GAP: begin
        if (qtick) begin
          scl_d = 1'b1;
          sda_d = 1'b1;
          gap_d = gap_q + 1'b1;
          if (gap_q == GW'(GAP_TICKS - 1)) begin
            // A pending NACK here means a retry of the same idx.
            if (nack_q) begin
              state_d = S_START;
            end else if (idx_q == 3'd7) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_START;
`ifdef WM8731_NACK_RETRY_EN
              retry_d = '0;
`endif
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_wm8731_i2c_seq.sv
// Bench for wm8731_i2c_seq: I2C slave model decodes bytes, scenario table plus hand sequences.
module tb_wm8731_i2c_seq;
`ifdef WM8731_NACK_RETRY_EN
  localparam int MAX_RETRY = 3;
`else
  localparam int MAX_RETRY = 0;
`endif
  localparam int DEV_ADDR = 'h1A;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, error, scl_o, sda_o, sda_i;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  wm8731_i2c_seq dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .scl_o(scl_o), .sda_o(sda_o), .sda_i(sda_i), .dbg_state(dbg_state)
  );

  // ---------------- I2C slave model / monitor ----------------
  logic       ack_drive = 1'b0;
  logic       scl_p = 1'b1, sda_p = 1'b1, in_frame = 1'b0;
  logic [7:0] shr = '0;
  int         start_cnt = 0, stop_cnt = 0, edge_cnt = 0, bit_n = 0, byte_cnt = 0;
  int         nack_budget = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  time        fall_t[$];

  assign sda_i = sda_o & ~ack_drive;

  always @(negedge clk) begin
    logic sda_l;
    if (!rst) begin
      in_frame  = 1'b0;
      bit_n     = 0;
      ack_drive = 1'b0;
    end else begin
      sda_l = sda_o & ~ack_drive;
      if (scl_o != scl_p || sda_l != sda_p) edge_cnt++;
      if (scl_o && scl_p && sda_p && !sda_l) begin
        start_cnt++;
        in_frame = 1'b1;
        bit_n    = 0;
        byte_cnt = 0;
      end else if (scl_o && scl_p && !sda_p && sda_l) begin
        stop_cnt++;
        in_frame = 1'b0;
      end else if (in_frame && scl_o && !scl_p) begin
        if (bit_n < 8) shr = {shr[6:0], sda_l};
        bit_n++;
        if (bit_n == 8) begin
          got_q.push_back(shr);
          byte_cnt++;
        end
      end else if (in_frame && !scl_o && scl_p) begin
        if (fall_t.size() < 4) fall_t.push_back($time);
        if (bit_n == 8) begin
          if (shr == 8'h08 && byte_cnt == 2 && nack_budget > 0) begin
            nack_budget--;
            ack_drive = 1'b0;
          end else begin
            ack_drive = 1'b1;
          end
        end else if (bit_n == 9) begin
          ack_drive = 1'b0;
          bit_n     = 0;
        end
      end
    end
    scl_p = scl_o;
    sda_p = sda_o & ~ack_drive;
  end

  // ---------------- reference model ----------------
  int tbl_addr[8] = '{'h0F, 'h06, 'h04, 'h05, 'h07, 'h08, 'h09, 'h06};
  int tbl_data[8] = '{'h000, 'h072, 'h012, 'h000, 'h00A, 'h000, 'h001, 'h062};

  // Slave NACKs the second byte of the idx-2 word while its budget lasts.
  task automatic build_exp(input int budget, output bit e_done, output bit e_err,
                           output int e_starts);
    int left, tries;
    bit sent;
    exp_q.delete();
    left = budget; e_err = 1'b0; e_starts = 0;
    for (int i = 0; i < 8 && !e_err; i++) begin
      tries = 0;
      sent  = 1'b0;
      while (!sent && !e_err) begin
        e_starts++;
        exp_q.push_back(8'(DEV_ADDR * 2));
        exp_q.push_back(8'(tbl_addr[i] * 2 + tbl_data[i] / 256));
        if (i == 2 && left > 0) begin
          left--;
          tries++;
          if (tries > MAX_RETRY) e_err = 1'b1;
        end else begin
          exp_q.push_back(8'(tbl_data[i] % 256));
          sent = 1'b1;
        end
      end
    end
    e_done = !e_err;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_stream(input string name);
    int n;
    chk({name, " byte count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s byte %0d", name, i), got_q[i], exp_q[i]);
  endtask

  task automatic clear_mon();
    got_q.delete();
    fall_t.delete();
    start_cnt = 0; stop_cnt = 0; bit_n = 0; byte_cnt = 0; in_frame = 1'b0;
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_start(output time t0);
    @(negedge clk); start = 1'b1;
    @(posedge clk); t0 = $time;
    @(negedge clk); start = 1'b0;
    chk("busy after start", busy, 1);
    chk("done cleared by start", done, 0);
    chk("error cleared by start", error, 0);
  endtask

  task automatic wait_idle(input time t0, input bit do_timing);
    int  n;
    time t_end;
    n = 0;
    while (busy && n < 20000) begin @(negedge clk); n++; end
    t_end = $time - 5;
    chk("sequence ends within budget", busy, 0);
    checks++;
    if (fall_t.size() < 3) begin
      errors++;
      $display("FAIL scl falls: got %0d edges required 3", fall_t.size());
    end else begin
      chk("start to first scl fall clk", 32'((fall_t[0] - 5 - t0) / 10), 32);
      chk("scl period clk", 32'((fall_t[2] - fall_t[1]) / 10), 32);
    end
    if (do_timing) chk("start to done clk", 32'((t_end - t0) / 10), 8448);
  endtask

  typedef struct {
    int budget;
    bit e_done;
    bit e_err;
    int e_starts;
  } scen_t;

  scen_t tbl[4];

  initial begin
    time t0;
    bit  m_done, m_err;
    int  m_starts, n;

`ifdef WM8731_NACK_RETRY_EN
    tbl[0] = '{0, 1'b1, 1'b0, 8};
    tbl[1] = '{1, 1'b1, 1'b0, 9};
    tbl[2] = '{9, 1'b0, 1'b1, 6};
`else
    tbl[0] = '{0, 1'b1, 1'b0, 8};
    tbl[1] = '{1, 1'b0, 1'b1, 3};
    tbl[2] = '{9, 1'b0, 1'b1, 3};
`endif
    tbl[3].budget = $urandom_range(0, 6);
    build_exp(tbl[3].budget, m_done, m_err, m_starts);
    tbl[3].e_done = m_done; tbl[3].e_err = m_err; tbl[3].e_starts = m_starts;

    // Reset held, then released; lines must stay quiet without start.
    repeat (5) @(negedge clk);
    chk("reset scl_o", scl_o, 1);
    chk("reset sda_o", sda_o, 1);
    chk("reset busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle done", done, 0);
    chk("idle error", error, 0);
    chk("idle state", dbg_state, 0);
    edge_cnt = 0;
    repeat (1000) @(negedge clk);
    chk("no line edges while idle", edge_cnt, 0);
    chk("still idle", busy, 0);

    // Scenario table: slave NACK budget against done/error/START count and byte stream.
    for (int s = 0; s < 4; s++) begin
      build_exp(tbl[s].budget, m_done, m_err, m_starts);
      clear_mon();
      nack_budget = tbl[s].budget;
      pulse_start(t0);
      wait_idle(t0, tbl[s].budget == 0);
      chk($sformatf("scen%0d done", s), done, tbl[s].e_done);
      chk($sformatf("scen%0d error", s), error, tbl[s].e_err);
      chk($sformatf("scen%0d starts", s), start_cnt, tbl[s].e_starts);
      chk($sformatf("scen%0d stops", s), stop_cnt, tbl[s].e_starts);
      cmp_stream($sformatf("scen%0d", s));
      if (s == 0 && got_q.size() >= 21) begin
        chk("entry0 b1", got_q[0], 'h34);  chk("entry0 b2", got_q[1], 'h1E);
        chk("entry0 b3", got_q[2], 'h00);  chk("entry4 b2", got_q[13], 'h0E);
        chk("entry4 b3", got_q[14], 'h0A); chk("entry6 b2", got_q[19], 'h12);
        chk("entry6 b3", got_q[20], 'h01);
      end
    end

    // start pulsed mid-sequence and again on the edge where done rises: both ignored.
    build_exp(0, m_done, m_err, m_starts);
    clear_mon();
    nack_budget = 0;
    pulse_start(t0);
    repeat ($urandom_range(50, 8000)) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while ($time < t0 + 84480 - 5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done on schedule", done, 1);
    chk("busy low at done", busy, 0);
    repeat (50) @(negedge clk);
    chk("start at done edge ignored", busy, 0);
    chk("done stays sticky", done, 1);
    chk("mid start starts", start_cnt, 8);
    cmp_stream("mid start");

    // start after done: done clears and the sequence repeats.
    clear_mon();
    pulse_start(t0);
    wait_idle(t0, 1'b1);
    chk("repeat done", done, 1);
    cmp_stream("repeat");

    // Asynchronous reset during byte 2 of idx 3, then a full restart.
    clear_mon();
    pulse_start(t0);
    n = 0;
    while (!(start_cnt == 4 && byte_cnt == 1 && bit_n == 3) && n < 20000) begin
      @(negedge clk); n++;
    end
    chk("reached idx3 byte2", (start_cnt == 4 && byte_cnt == 1), 1);
    #2 rst = 1'b0;
    #1;
    chk("async rst scl_o", scl_o, 1);
    chk("async rst sda_o", sda_o, 1);
    chk("async rst busy", busy, 0);
    chk("async rst done", done, 0);
    chk("async rst error", error, 0);
    chk("async rst state", dbg_state, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    clear_mon();
    pulse_start(t0);
    wait_idle(t0, 1'b1);
    chk("post reset done", done, 1);
    chk("post reset starts", start_cnt, 8);
    cmp_stream("post reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
